// File: rtl/aes_stream_arbiter_pkg.sv
// Shared definitions for the AES stream arbiter: channel limit, FSM states, tag sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package aes_stream_arbiter_pkg;

   // Largest requester count the arbiter is built for.
   localparam int MAX_CH = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FWD  = 1'b1
   } arb_state_t;

   // Bits needed to index `value` entries; never less than 1 so a 1-bit tag still exists.
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/aes_stream_arbiter_if.sv
// Bundles the request streams, AES controller ports and result streams of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: carried on s_tready / ctrl_in_busy / ctrl_out_tready / m_tready.
interface aes_stream_arbiter_if #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CH-1:0]            s_tvalid;
   logic [NUM_CH-1:0]            s_tready;
   logic [NUM_CH-1:0]            s_tlast;
   logic [NUM_CH*DATA_WIDTH-1:0] s_tdata;

   logic                         ctrl_wren;
   logic                         ctrl_tlast;
   logic [DATA_WIDTH-1:0]        ctrl_data;
   logic                         ctrl_in_busy;

   logic                         ctrl_out_tvalid;
   logic [DATA_WIDTH-1:0]        ctrl_out_tdata;
   logic                         ctrl_out_tlast;
   logic                         ctrl_out_tready;

   logic [NUM_CH-1:0]            m_tvalid;
   logic [NUM_CH-1:0]            m_tlast;
   logic [NUM_CH-1:0]            m_tready;
   logic [DATA_WIDTH-1:0]        m_tdata;

   // Arbiter view.
   modport master (
      input  s_tvalid, s_tlast, s_tdata, ctrl_in_busy,
      input  ctrl_out_tvalid, ctrl_out_tdata, ctrl_out_tlast, m_tready,
      output s_tready, ctrl_wren, ctrl_tlast, ctrl_data,
      output ctrl_out_tready, m_tvalid, m_tlast, m_tdata
   );

   // Requester / controller / consumer view.
   modport slave (
      output s_tvalid, s_tlast, s_tdata, ctrl_in_busy,
      output ctrl_out_tvalid, ctrl_out_tdata, ctrl_out_tlast, m_tready,
      input  s_tready, ctrl_wren, ctrl_tlast, ctrl_data,
      input  ctrl_out_tready, m_tvalid, m_tlast, m_tdata
   );

endinterface

// File: rtl/aes_tag_fifo.sv
// In-order FIFO of channel tags for packets handed to the AES controller.
// Latency: push visible at head one cycle later; pop takes effect on the clock edge.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
module aes_tag_fifo
   import aes_stream_arbiter_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = clogb2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Tag storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/aes_stream_arbiter.sv
// Round-robin packet arbiter feeding one AES controller and routing its results back by tag.
// Latency: one IDLE arbitration cycle per packet, then zero-latency beat forwarding both ways.
// Backpressure: ctrl_in_busy stalls the granted channel; m_tready of the head tag stalls results.
module aes_stream_arbiter
   import aes_stream_arbiter_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_DEPTH  = 4
) (
   input logic                  clk,
   input logic                  reset,
   aes_stream_arbiter_if.master bus
);
   localparam int TW = clogb2(NUM_CH);

   arb_state_t        state, state_nxt;
   logic [TW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [TW-1:0]     grant, grant_nxt;
   logic [TW-1:0]     pick;
   logic              pick_vld;
   logic              tag_push, tag_pop, tag_full, tag_empty;
   logic [TW-1:0]     tag_head;
   logic [NUM_CH-1:0] s_tready_c, m_tvalid_c, m_tlast_c;
   logic              wren_c, tlast_c, out_rdy_c;

   // Channel index base+off wrapped into 0..NUM_CH-1.
   function automatic logic [TW-1:0] wrap_idx(input logic [TW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return TW'(s);
   endfunction

   // First requesting channel at or after rr_ptr; scanning downward lets the nearest win.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bus.s_tvalid[wrap_idx(rr_ptr, i)]) begin
            pick_vld = 1'b1;
            pick     = wrap_idx(rr_ptr, i);
         end
      end
   end

   // Arbitration state, grant holder and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // Grant when a tag slot is free, then forward the holder's beats until its tlast.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      tag_push   = 1'b0;
      s_tready_c = '0;
      wren_c     = 1'b0;
      tlast_c    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld && !tag_full) begin
               grant_nxt = pick;
               tag_push  = 1'b1;
               state_nxt = FWD;
            end
         end
         FWD: begin
            s_tready_c[grant] = !bus.ctrl_in_busy;
            wren_c            = bus.s_tvalid[grant] && !bus.ctrl_in_busy;
            tlast_c           = bus.s_tlast[grant];
            if (wren_c && bus.s_tlast[grant]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = wrap_idx(grant, 1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Results go to the channel whose tag is oldest; nothing is routed without a tag.
   always_comb begin
      m_tvalid_c = '0;
      m_tlast_c  = '0;
      out_rdy_c  = 1'b0;
      if (!tag_empty) begin
         m_tvalid_c[tag_head] = bus.ctrl_out_tvalid;
         m_tlast_c[tag_head]  = bus.ctrl_out_tlast;
         out_rdy_c            = bus.m_tready[tag_head];
      end
   end

   assign tag_pop = !tag_empty && bus.ctrl_out_tvalid && out_rdy_c && bus.ctrl_out_tlast;

   // Reset masks the handshake outputs immediately so nothing leaks while it is held.
   assign bus.s_tready        = reset ? '0   : s_tready_c;
   assign bus.ctrl_wren       = reset ? 1'b0 : wren_c;
   assign bus.ctrl_tlast      = reset ? 1'b0 : tlast_c;
   assign bus.ctrl_data       = bus.s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.m_tvalid        = reset ? '0   : m_tvalid_c;
   assign bus.m_tlast         = reset ? '0   : m_tlast_c;
   assign bus.ctrl_out_tready = reset ? 1'b0 : out_rdy_c;
   assign bus.m_tdata         = bus.ctrl_out_tdata;

   aes_tag_fifo #(
      .WIDTH (TW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (tag_push),
      .push_dat (grant_nxt),
      .pop      (tag_pop),
      .head     (tag_head),
      .full     (tag_full),
      .empty    (tag_empty)
   );

endmodule
